// File: rtl/bayes_pkg.sv
// Shared constants and types for the bayes_accumulate block: default
// widths and class/observation counts, plus the control FSM state type.
package bayes_pkg;

  localparam int M_DEF       = 8;
  localparam int N_CLASS_DEF = 4;
  localparam int N_OBS_DEF   = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_e;

endpackage : bayes_pkg

// File: rtl/acc_lane.sv
// One saturating log-probability accumulator lane. clr_i zeroes the lane at
// the start of an inference; en_i adds add_i with saturation to all-ones.
// sat_o is a sticky flag raised the first time an add carries out of M bits.
module acc_lane
  import bayes_pkg::*;
#(
  parameter int M = M_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [M-1:0] add_i,
  output logic [M-1:0] acc_o,
  output logic         sat_o
);

  logic [M-1:0] acc_q, acc_d;
  logic         sat_q, sat_d;
  logic [M:0]   sum;

  // Next-state: widen by one bit so the carry out selects saturation.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    acc_d = acc_q;
    sat_d = sat_q;
    sum   = {1'b0, acc_q} + {1'b0, add_i};
    if (clr_i) begin
      acc_d = '0;
      sat_d = 1'b0;
    end else if (en_i) begin
      if (sum[M]) begin
        acc_d = '1;
        sat_d = 1'b1;
      end else begin
        acc_d = sum[M-1:0];
      end
    end
  end

  // Accumulator register; once all-ones, any further add carries again,
  // so a saturated lane stays saturated for the rest of the inference.
  always_ff @(posedge clk) begin
    // NOTE: the accumulator is reset even though it is cleared by start, so no partial result survives a reset.
    if (rst) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment only.
      acc_q <= acc_d;
      sat_q <= sat_d;
    end
  end

  assign acc_o = acc_q;
  assign sat_o = sat_q;

endmodule : acc_lane

// File: rtl/bayes_accumulate.sv
// Naive-Bayes log-likelihood accumulator: sums a stream of class-minor
// log-likelihood beats into N_CLASS saturating accumulators, scans them for
// the maximum (ties to the lowest index) and presents the winner with a
// valid/ready handshake.
// Optional feature macro: BAYES_SAT_FLAG_EN adds the sat_flag output.
module bayes_accumulate
  import bayes_pkg::*;
#(
  parameter int M       = M_DEF,
  parameter int N_CLASS = N_CLASS_DEF,
  parameter int N_OBS   = N_OBS_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [M-1:0]               in_proba,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(N_CLASS)-1:0] out_class,
  output logic [M-1:0]               out_score,
  output logic                       busy
`ifdef BAYES_SAT_FLAG_EN
  ,
  output logic                       sat_flag
`endif
);

  localparam int CW = (N_CLASS > 1) ? $clog2(N_CLASS) : 1;
  localparam int OW = (N_OBS > 1) ? $clog2(N_OBS) : 1;
  localparam int SW = $clog2(N_CLASS + 1);

  localparam logic [CW-1:0] CLS_LAST  = CW'(N_CLASS - 1);
  localparam logic [OW-1:0] OBS_LAST  = OW'(N_OBS - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(N_CLASS);

  state_e        state_q, state_d;
  logic [CW-1:0] cls_q, cls_d;
  logic [OW-1:0] obs_q, obs_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [CW-1:0] best_idx_q, best_idx_d;
  logic [M-1:0]  best_score_q, best_score_d;
  logic [CW-1:0] out_class_q, out_class_d;
  logic [M-1:0]  out_score_q, out_score_d;

  logic               clr_acc;
  logic               beat_acc;
  logic [M-1:0]       acc_scan;
  logic [CW-1:0]      scan_idx;
  logic [M-1:0]       acc_vals [N_CLASS];
  logic [N_CLASS-1:0] lane_sat;

  assign beat_acc = (state_q == ACCUM) && in_valid;
  assign scan_idx = scan_q[CW-1:0];
  assign acc_scan = acc_vals[scan_idx];

  // One accumulator lane per class; only the lane addressed by the class
  // counter adds the current beat.
  for (genvar g = 0; g < N_CLASS; g++) begin : g_lane
    acc_lane #(.M(M)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .clr_i (clr_acc),
      .en_i  (beat_acc && (cls_q == CW'(g))),
      .add_i (in_proba),
      .acc_o (acc_vals[g]),
      .sat_o (lane_sat[g])
    );
  end

  // Next-state, counters, max-scan and handshake outputs.
  always_comb begin
    state_d      = state_q;
    cls_d        = cls_q;
    obs_d        = obs_q;
    scan_d       = scan_q;
    best_idx_d   = best_idx_q;
    best_score_d = best_score_q;
    out_class_d  = out_class_q;
    out_score_d  = out_score_q;
    clr_acc      = 1'b0;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b1;

    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          clr_acc = 1'b1;
          cls_d   = '0;
          obs_d   = '0;
          state_d = ACCUM;
        end
      end

      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (cls_q == CLS_LAST) begin
            cls_d = '0;
            if (obs_q == OBS_LAST) begin
              obs_d   = '0;
              scan_d  = '0;
              state_d = COMPARE;
            end else begin
              obs_d = obs_q + 1'b1;
            end
          end else begin
            cls_d = cls_q + 1'b1;
          end
        end
      end

      // Scan indices 0..N_CLASS-1 one per cycle, then commit the winner.
      COMPARE: begin
        if (scan_q == SCAN_LAST) begin
          out_class_d = best_idx_q;
          out_score_d = best_score_q;
          state_d     = DONE;
        end else begin
          if ((scan_q == '0) || (acc_scan > best_score_q)) begin
            best_idx_d   = scan_idx;
            best_score_d = acc_scan;
          end
          scan_d = scan_q + 1'b1;
        end
      end

      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: beat counters, scan pointer, running best, result.
  always_ff @(posedge clk) begin
    if (rst) begin
      cls_q        <= '0;
      obs_q        <= '0;
      scan_q       <= '0;
      best_idx_q   <= '0;
      best_score_q <= '0;
      out_class_q  <= '0;
      out_score_q  <= '0;
    end else begin
      cls_q        <= cls_d;
      obs_q        <= obs_d;
      scan_q       <= scan_d;
      best_idx_q   <= best_idx_d;
      best_score_q <= best_score_d;
      out_class_q  <= out_class_d;
      out_score_q  <= out_score_d;
    end
  end

  assign out_class = out_class_q;
  assign out_score = out_score_q;

`ifdef BAYES_SAT_FLAG_EN
  // Lanes keep their sticky saturation bit until the next start or reset.
  assign sat_flag = |lane_sat;
`else
  logic unused_sat;
  assign unused_sat = |lane_sat;
`endif

endmodule : bayes_accumulate
